pipe_ctrl: RTL and testbench
============================

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 The block SHALL have parameter MDU_CYCLES, default 4: EX-occupancy cycles of a multi-cycle MDU op; legal range 2..15.
REQ-002 The block SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rstn, input, 1: reset, synchronous, active-low.
REQ-004 The block SHALL have ports id_rs and id_rt, input, 5 each: source register numbers of the instruction in ID.
REQ-005 The block SHALL have ports id_uses_rs and id_uses_rt, input, 1 each: the ID instruction reads rs / rt.
REQ-006 The block SHALL have port id_mdu_start, input, 1: the ID instruction is a multi-cycle MDU op.
REQ-007 The block SHALL have ports ex_regwrite, input, 1; ex_memread, input, 1; ex_wreg, input, 5: EX-stage write-back info.
REQ-008 The block SHALL have ports mem_regwrite, input, 1; mem_wreg, input, 5: MEM-stage write-back info.
REQ-009 The block SHALL have port ex_branch_taken, input, 1: the branch resolved in EX is taken.
REQ-010 The block SHALL have ports pc_en, ifid_en, ifid_flush and idex_flush, output, 1 each: PC enable, IF/ID enable, IF/ID clear, ID/EX bubble (all EX control fields zero).
REQ-011 The block SHALL have ports mdu_busy and mdu_done, output, 1 each: MDU running; one-cycle completion pulse.
REQ-012 The block SHALL have ports fwd_a and fwd_b, output, 2 each, registered: EX operand select; 00 register file, 10 EX/MEM, 01 MEM/WB.

Function
REQ-013 The FSM SHALL have states IDLE, RUN and DONE, plus a 4-bit down-counter cnt.
REQ-014 A load-use hazard SHALL be ex_memread and ex_wreg!=0 and ((id_uses_rs and id_rs==ex_wreg) or (id_uses_rt and id_rt==ex_wreg)).
REQ-015 Flush priority SHALL be highest: ex_branch_taken=1 forces ifid_flush=1 and idex_flush=1 with pc_en=1, ifid_en=1, regardless of FSM state or hazards.
REQ-016 A stall (pc_en=0, ifid_en=0, idex_flush=1, ifid_flush=0) SHALL be asserted when there is no branch flush and the FSM is in RUN, or there is a load-use hazard, or (without the forwarding feature) there is a RAW hazard.
REQ-017 With no flush and no stall, outputs SHALL be pc_en=1, ifid_en=1, ifid_flush=0 and idex_flush=0.
REQ-018 In IDLE, with id_mdu_start=1 and neither flush nor stall, the FSM SHALL go to RUN with cnt<=MDU_CYCLES-1; the MDU op advances that cycle.
REQ-019 In RUN, cnt SHALL decrement each cycle; at cnt==1 the FSM SHALL go to DONE.
REQ-020 In DONE, mdu_done SHALL be 1 for exactly one cycle, no stall SHALL come from the FSM, and the next state SHALL be IDLE; a new id_mdu_start is accepted only from IDLE.
REQ-021 mdu_busy SHALL be 1 exactly in RUN.
REQ-022 Total ID stall due to an MDU op SHALL be MDU_CYCLES-1 cycles.
REQ-023 ex_branch_taken in RUN SHALL apply the flush without altering FSM state or cnt.
REQ-024 Register number 0 SHALL never produce a hazard or forward.

Reset
REQ-025 While rstn=0 at a clk edge, the FSM SHALL be set to IDLE, cnt to 0, and fwd_a and fwd_b to 00.
REQ-026 While rstn=0, combinational outputs SHALL be forced to pc_en=0, ifid_en=0, ifid_flush=1, idex_flush=1, mdu_busy=0 and mdu_done=0.
REQ-027 Reset asserted during RUN SHALL abort the MDU sequence with no mdu_done pulse.

Configuration
REQ-028 The forwarding feature SHALL be compiled in by defining macro PIPE_CTRL_FWD_EN.
REQ-029 With PIPE_CTRL_FWD_EN defined, on each edge with idex_flush=0, fwd_a SHALL get 10 if ex_regwrite and ex_wreg==id_rs, else 01 if mem_regwrite and mem_wreg==id_rs, else 00; fwd_b SHALL be computed the same way using id_rt; when idex_flush=1, both SHALL get 00.
REQ-030 Without PIPE_CTRL_FWD_EN, fwd_a and fwd_b SHALL be constant 00.
REQ-031 Without PIPE_CTRL_FWD_EN, a RAW hazard SHALL be any used source (id_rs or id_rt with its use flag set) matching ex_wreg with ex_regwrite=1, or mem_wreg with mem_regwrite=1; the stall holds until no match remains.

Verification
REQ-032 Reset: rstn=0 for 2 cycles, then 1 -> during reset pc_en=0, idex_flush=1, fwd=00; first cycle after reset pc_en=1, state IDLE.
REQ-033 Load-use: ex_memread=1, ex_wreg=5, id_rs=5, id_uses_rs=1 -> exactly one cycle with pc_en=0, idex_flush=1; next cycle, with ex_memread=0, pc_en=1.
REQ-034 MDU: MDU_CYCLES=4, id_mdu_start=1 in IDLE -> mdu_busy=1 for 3 cycles, then mdu_done=1 for 1 cycle; pc_en=0 for exactly those 3 cycles.
REQ-035 Branch vs stall: ex_branch_taken=1 together with a load-use hazard -> ifid_flush=1, idex_flush=1, pc_en=1.
REQ-036 Forwarding (macro defined): ex_regwrite=1, ex_wreg=7, mem_regwrite=1, mem_wreg=7, id_rt=7 -> fwd_b=10 next cycle; with ex_wreg=0 and mem_wreg=7 -> fwd_b=01.
REQ-037 No forwarding (macro undefined): mem_regwrite=1, mem_wreg=3, id_rs=3, id_uses_rs=1 -> stall asserted while the match persists; fwd_a stays 00.

Source files
------------

// File: rtl/pipe_ctrl.sv
// ============================================================================
// Module   : pipe_ctrl
// Brief    : Pipeline hazard controller for a 5-stage core. Generates the
//            PC / IF/ID enables, IF/ID and ID/EX flushes, load-use and RAW
//            stalls, sequences multi-cycle MDU ops, and (optionally) registers
//            the EX operand forwarding selects.
// Options  : define PIPE_CTRL_FWD_EN to build in operand forwarding; without
//            it RAW hazards stall and fwd_a / fwd_b are tied to 00.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_ctrl #(
  parameter int MDU_CYCLES = 4  // EX occupancy of an MDU op, 2..15
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rs,
  input  logic       id_uses_rt,
  input  logic       id_mdu_start,
  input  logic       ex_regwrite,
  input  logic       ex_memread,
  input  logic [4:0] ex_wreg,
  input  logic       mem_regwrite,
  input  logic [4:0] mem_wreg,
  input  logic       ex_branch_taken,
  output logic       pc_en,
  output logic       ifid_en,
  output logic       ifid_flush,
  output logic       idex_flush,
  output logic       mdu_busy,
  output logic       mdu_done,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] C_CNT_INIT = 4'(MDU_CYCLES - 1);

  state_t     r_state;
  logic [3:0] r_cnt;

  logic w_load_use;
  logic w_raw;
  logic w_flush;
  logic w_stall;

  // A load in EX cannot forward in time; any consumer in ID must wait a cycle.
  assign w_load_use = ex_memread && (ex_wreg != 5'd0) &&
                      ((id_uses_rs && (id_rs == ex_wreg)) ||
                       (id_uses_rt && (id_rt == ex_wreg)));

`ifdef PIPE_CTRL_FWD_EN
  // With forwarding, ALU results reach EX through the bypass paths.
  assign w_raw = 1'b0;
`else
  // Without forwarding, ID waits until no in-flight writer matches a source.
  assign w_raw = (id_uses_rs && (id_rs != 5'd0) &&
                  ((ex_regwrite  && (id_rs == ex_wreg)) ||
                   (mem_regwrite && (id_rs == mem_wreg)))) ||
                 (id_uses_rt && (id_rt != 5'd0) &&
                  ((ex_regwrite  && (id_rt == ex_wreg)) ||
                   (mem_regwrite && (id_rt == mem_wreg))));
`endif

  // A taken branch outranks every stall source.
  assign w_flush = ex_branch_taken;
  assign w_stall = !w_flush && ((r_state == RUN) || w_load_use || w_raw);

  // Pipeline control: reset, then flush, then stall, else free-running.
  always_comb begin
    pc_en      = 1'b1;
    ifid_en    = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    if (!rstn) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (w_flush) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (w_stall) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
    end
  end

  // Status decoded from the state register, masked while reset is held.
  assign mdu_busy = rstn && (r_state == RUN);
  assign mdu_done = rstn && (r_state == DONE);

  // MDU sequencer: the op advances on entry, ID is held for the RUN cycles.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (id_mdu_start && !w_flush && !w_stall) begin
            r_state <= RUN;
            r_cnt   <= C_CNT_INIT;
          end
        end
        RUN: begin
          // A taken branch freezes the sequence for that cycle.
          if (!w_flush) begin
            r_cnt <= r_cnt - 4'd1;
            if (r_cnt == 4'd1) begin
              r_state <= DONE;
            end
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= 4'd0;
        end
      endcase
    end
  end

`ifdef PIPE_CTRL_FWD_EN
  logic [1:0] r_fwd_a;
  logic [1:0] r_fwd_b;

  // Youngest producer wins; r0 is hard-wired zero and never forwarded.
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] src,
    input logic       exw,
    input logic [4:0] exr,
    input logic       memw,
    input logic [4:0] memr
  );
    if ((src != 5'd0) && exw && (exr == src)) begin
      return 2'b10;
    end else if ((src != 5'd0) && memw && (memr == src)) begin
      return 2'b01;
    end
    return 2'b00;
  endfunction

  // Forward selects follow the instruction into EX; a bubble gets 00.
  always_ff @(posedge clk) begin
    if (!rstn || idex_flush) begin
      r_fwd_a <= 2'b00;
      r_fwd_b <= 2'b00;
    end else begin
      r_fwd_a <= fwd_sel(id_rs, ex_regwrite, ex_wreg, mem_regwrite, mem_wreg);
      r_fwd_b <= fwd_sel(id_rt, ex_regwrite, ex_wreg, mem_regwrite, mem_wreg);
    end
  end

  assign fwd_a = r_fwd_a;
  assign fwd_b = r_fwd_b;
`else
  assign fwd_a = 2'b00;
  assign fwd_b = 2'b00;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
// ============================================================================
// Module   : tb_pipe_ctrl
// Brief    : Self-checking bench for pipe_ctrl. A cycle-level model tracks the
//            remaining MDU busy cycles and the expected forward selects; every
//            cycle is compared, and directed scenarios pin literal values.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipe_ctrl;

  localparam int MDU = 4;

  logic       clk = 1'b0;
  logic       rstn;
  logic [4:0] id_rs, id_rt, ex_wreg, mem_wreg;
  logic       id_uses_rs, id_uses_rt, id_mdu_start;
  logic       ex_regwrite, ex_memread, mem_regwrite, ex_branch_taken;
  logic       pc_en, ifid_en, ifid_flush, idex_flush, mdu_busy, mdu_done;
  logic [1:0] fwd_a, fwd_b;

  int n_checks = 0;
  int n_errors = 0;

  pipe_ctrl #(.MDU_CYCLES(MDU)) dut (
    .clk(clk), .rstn(rstn),
    .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_mdu_start(id_mdu_start),
    .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_wreg(ex_wreg),
    .mem_regwrite(mem_regwrite), .mem_wreg(mem_wreg),
    .ex_branch_taken(ex_branch_taken),
    .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
    .idex_flush(idex_flush), .mdu_busy(mdu_busy), .mdu_done(mdu_done),
    .fwd_a(fwd_a), .fwd_b(fwd_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int         m_run_left = 0;  // ID-stall cycles still owed to the MDU
  bit         m_done     = 0;  // completion pulse due this cycle
  logic [1:0] m_fa       = 2'b00;
  logic [1:0] m_fb       = 2'b00;

  function automatic bit src_hit(input logic use_f, input logic [4:0] r, input logic w, input logic [4:0] wr);
    return use_f && (r != 5'd0) && w && (r == wr);
  endfunction

  // Expected {pc_en, ifid_en, ifid_flush, idex_flush, mdu_busy, mdu_done}
  function automatic logic [5:0] model_out();
    bit lu, raw;
    if (!rstn) return 6'b001100;
    lu  = src_hit(id_uses_rs, id_rs, ex_memread, ex_wreg) ||
          src_hit(id_uses_rt, id_rt, ex_memread, ex_wreg);
    raw = 1'b0;
`ifndef PIPE_CTRL_FWD_EN
    raw = src_hit(id_uses_rs, id_rs, ex_regwrite, ex_wreg) ||
          src_hit(id_uses_rs, id_rs, mem_regwrite, mem_wreg) ||
          src_hit(id_uses_rt, id_rt, ex_regwrite, ex_wreg) ||
          src_hit(id_uses_rt, id_rt, mem_regwrite, mem_wreg);
`endif
    if (ex_branch_taken) return {4'b1111, m_run_left > 0, m_done};
    if (m_run_left > 0 || lu || raw) return {4'b0001, m_run_left > 0, m_done};
    return {4'b1100, 1'b0, m_done};
  endfunction

  function automatic logic [1:0] model_fwd(input logic [4:0] r);
`ifdef PIPE_CTRL_FWD_EN
    if (r != 0 && ex_regwrite && ex_wreg == r) return 2'b10;
    if (r != 0 && mem_regwrite && mem_wreg == r) return 2'b01;
`endif
    return 2'b00;
  endfunction

  always @(posedge clk) begin
    logic [5:0] o;
    o = model_out();
    if (!rstn) begin
      m_run_left = 0; m_done = 0; m_fa = 2'b00; m_fb = 2'b00;
    end else begin
      m_fa = o[2] ? 2'b00 : model_fwd(id_rs);
      m_fb = o[2] ? 2'b00 : model_fwd(id_rt);
      if (m_run_left > 0) begin
        if (!ex_branch_taken) begin
          m_run_left--;
          if (m_run_left == 0) m_done = 1;
        end
      end else if (m_done) begin
        m_done = 0;
      end else if (id_mdu_start && o[5] && !o[3]) begin
        m_run_left = MDU - 1;
      end
    end
  end

  // Single compare process, mid-cycle
  always @(negedge clk) begin
    logic [5:0] o;
    o = model_out();
    chk("pc_en",      pc_en,      o[5]);
    chk("ifid_en",    ifid_en,    o[4]);
    chk("ifid_flush", ifid_flush, o[3]);
    chk("idex_flush", idex_flush, o[2]);
    chk("mdu_busy",   mdu_busy,   o[1]);
    chk("mdu_done",   mdu_done,   o[0]);
    chk("fwd_a",      fwd_a,      m_fa);
    chk("fwd_b",      fwd_b,      m_fb);
  end

  // ---------------- directed stimulus ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    id_rs = 0; id_rt = 0; id_uses_rs = 0; id_uses_rt = 0; id_mdu_start = 0;
    ex_regwrite = 0; ex_memread = 0; ex_wreg = 0;
    mem_regwrite = 0; mem_wreg = 0; ex_branch_taken = 0;
  endtask

  // Issue an MDU op, optionally branch/reset on a given later cycle, then
  // count busy, done and stall cycles over a bounded window.
  task automatic run_mdu(input int br_at, input int rst_at,
                         output int busy_n, output int done_n, output int stall_n, output int done_idx);
    busy_n = 0; done_n = 0; stall_n = 0; done_idx = -1;
    id_mdu_start = 1;
    next_cycle();
    id_mdu_start = 0;
    for (int i = 0; i < 8; i++) begin
      ex_branch_taken = (i == br_at);
      rstn = (i != rst_at);
      @(negedge clk);
      if (mdu_busy) busy_n++;
      if (mdu_done) begin done_n++; if (done_idx < 0) done_idx = i; end
      if (!pc_en && rstn) stall_n++;
      next_cycle();
    end
    ex_branch_taken = 0; rstn = 1;
  endtask

  initial begin
    int b, d, s, di;
    idle_inputs();
    rstn = 0;
    // Reset held for two edges
    @(negedge clk);
    chk("rst pc_en", pc_en, 1'b0);
    chk("rst idex_flush", idex_flush, 1'b1);
    next_cycle();
    @(negedge clk);
    chk("rst fwd", {fwd_a, fwd_b}, 4'b0000);
    next_cycle();
    rstn = 1;
    @(negedge clk);
    chk("post-rst pc_en", pc_en, 1'b1);
    chk("post-rst busy", mdu_busy, 1'b0);

    // Load-use: one stall cycle, then free
    next_cycle();
    ex_memread = 1; ex_wreg = 5; id_rs = 5; id_uses_rs = 1;
    @(negedge clk);
    chk("lu pc_en", pc_en, 1'b0);
    chk("lu idex_flush", idex_flush, 1'b1);
    next_cycle();
    ex_memread = 0;
    @(negedge clk);
    chk("lu release pc_en", pc_en, 1'b1);
    next_cycle();
    idle_inputs();

    // Load-use on r0 never stalls
    ex_memread = 1; ex_wreg = 0; id_rs = 0; id_uses_rs = 1;
    @(negedge clk);
    chk("lu r0 pc_en", pc_en, 1'b1);
    next_cycle();
    idle_inputs();

    // Branch beats load-use
    ex_memread = 1; ex_wreg = 9; id_rt = 9; id_uses_rt = 1; ex_branch_taken = 1;
    @(negedge clk);
    chk("br ifid_flush", ifid_flush, 1'b1);
    chk("br idex_flush", idex_flush, 1'b1);
    chk("br pc_en", pc_en, 1'b1);
    next_cycle();
    idle_inputs();

    // Plain MDU op
    run_mdu(-1, -1, b, d, s, di);
    chk("mdu busy cycles", b, 3);
    chk("mdu done cycles", d, 1);
    chk("mdu stall cycles", s, 3);
    chk("mdu done index", di, 3);

    // Branch during RUN freezes the sequence one cycle
    run_mdu(1, -1, b, d, s, di);
    chk("mdu+br busy cycles", b, 4);
    chk("mdu+br stall cycles", s, 3);
    chk("mdu+br done index", di, 4);

    // Reset during RUN aborts without a done pulse
    run_mdu(1, 1, b, d, s, di);
    chk("mdu abort done", d, 0);

`ifdef PIPE_CTRL_FWD_EN
    ex_regwrite = 1; ex_wreg = 7; mem_regwrite = 1; mem_wreg = 7; id_rt = 7; id_uses_rt = 1;
    next_cycle();
    chk("fwd_b ex", fwd_b, 2'b10);
    ex_wreg = 0;
    next_cycle();
    chk("fwd_b mem", fwd_b, 2'b01);
    idle_inputs();
`else
    mem_regwrite = 1; mem_wreg = 3; id_rs = 3; id_uses_rs = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("raw pc_en", pc_en, 1'b0);
      chk("raw fwd_a", fwd_a, 2'b00);
      next_cycle();
    end
    mem_regwrite = 0;
    @(negedge clk);
    chk("raw release pc_en", pc_en, 1'b1);
    next_cycle();
    idle_inputs();
`endif

    // Mixed sweep, checked by the model every cycle
    for (int i = 0; i < 300; i++) begin
      id_rs = 5'($urandom_range(0, 3)); id_rt = 5'($urandom_range(0, 3));
      id_uses_rs = 1'($urandom_range(0, 1)); id_uses_rt = 1'($urandom_range(0, 1));
      id_mdu_start = ($urandom_range(0, 3) == 0);
      ex_regwrite = ($urandom_range(0, 2) == 0); ex_memread = ($urandom_range(0, 5) == 0);
      ex_wreg = 5'($urandom_range(0, 3));
      mem_regwrite = ($urandom_range(0, 2) == 0); mem_wreg = 5'($urandom_range(0, 3));
      ex_branch_taken = ($urandom_range(0, 7) == 0);
      rstn = ($urandom_range(0, 49) != 0);
      next_cycle();
    end
    idle_inputs();
    rstn = 1;
    next_cycle();
    next_cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
